uart_bridge_param: RTL and testbench

- Parametrised UART-to-UART bridge: receives serial frames on `rx`, buffers them in an internal synchronous FIFO and retransmits them on `tx`.
- Rx and tx run at independent, runtime-programmable bit rates.
- Adds configurable data width, FIFO depth, parity and error reporting.
- Sits between MCU and PC serial pins in the CPLD. Replaces the fixed 8-bit, 64-deep bridge with its external FIFO core.

---
 rtl/uart_bridge_param.sv | 162 ++++++++++++++++
 tb/tb_uart_bridge_param.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bridge_param.sv
// uart_bridge_param: UART-to-UART bridge that buffers received frames in a FIFO and retransmits them.
// Ports: clk/rst (sync, active-high); rx serial in; tx serial out; rx_div/tx_div clocks per bit (minimum 4);
//        par_mode 00 none / 01 even / 10 odd / 11 none; clr_err clears the sticky flags;
//        fifo_level occupancy; overflow/frame_err/parity_err sticky error flags.
// Optional: UART_CTS_EN adds cts_n (active-low clear-to-send) that gates the start of each tx frame.
module uart_bridge_param #(
  parameter int DW = 8,
  parameter int DEPTH = 64,
  parameter int AW = $clog2(DEPTH),
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  output logic             tx,
  input  logic [DIV_W-1:0] rx_div,
  input  logic [DIV_W-1:0] tx_div,
  input  logic [1:0]       par_mode,
  input  logic             clr_err,
`ifdef UART_CTS_EN
  input  logic             cts_n,
`endif
  output logic [AW:0]      fifo_level,
  output logic             overflow,
  output logic             frame_err,
  output logic             parity_err
);
  localparam int BW = $clog2(DW);
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rx_state_t;
  typedef enum logic [2:0] {T_IDLE, T_LOAD, T_START, T_DATA, T_PAR, T_STOP} tx_state_t;
  rx_state_t rstate, r_next;
  tx_state_t tstate, t_next;
  logic rx_meta, rx_sync, rx_prev;
  logic [DIV_W-1:0] rx_eff, tx_eff, rcnt, rdiv, tcnt, tdiv;
  logic [BW-1:0] rbit, tbit;
  logic [DW-1:0] rsh, tword;
  logic [DW-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic par_en, par_odd, r_tick, t_tick, rpar_bad, push, pop, set_fe, set_pe;
  logic full, empty, do_push, do_pop, ovf_set, can_pop, cts_ok, tx_bit;
  assign par_en = (par_mode == 2'b01) || (par_mode == 2'b10);
  assign par_odd = par_mode == 2'b10;
  assign rx_eff = (rx_div < DIV_W'(4)) ? DIV_W'(4) : rx_div;
  assign tx_eff = (tx_div < DIV_W'(4)) ? DIV_W'(4) : tx_div;
  assign r_tick = rcnt <= DIV_W'(1);
  assign t_tick = tcnt <= DIV_W'(1);
`ifdef UART_CTS_EN
  logic cts_meta, cts_sync;
  always_ff @(posedge clk) begin
    cts_meta <= rst ? 1'b1 : cts_n;
    cts_sync <= rst ? 1'b1 : cts_meta;
  end
  assign cts_ok = ~cts_sync;
`else
  assign cts_ok = 1'b1;
`endif
  always_comb begin
    r_next = rstate;
    push = 1'b0;
    set_fe = 1'b0;
    set_pe = 1'b0;
    case (rstate)
      R_IDLE: r_next = (rx_prev & ~rx_sync) ? R_START : R_IDLE;
      R_START: r_next = r_tick ? (rx_sync ? R_IDLE : R_DATA) : R_START;
      R_DATA: r_next = (r_tick && rbit == BW'(DW-1)) ? (par_en ? R_PAR : R_STOP) : R_DATA;
      R_PAR: begin
        r_next = r_tick ? R_STOP : R_PAR;
        set_pe = r_tick && ((^rsh ^ rx_sync) != par_odd);
      end
      R_STOP: begin
        r_next = r_tick ? R_IDLE : R_STOP;
        set_fe = r_tick & ~rx_sync;
        push = r_tick & rx_sync & ~rpar_bad;
      end
      default: r_next = R_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {rx_meta, rx_sync, rx_prev} <= 3'b111;
      rstate <= R_IDLE;
      rcnt <= '0;
      rdiv <= DIV_W'(4);
      rbit <= '0;
      rsh <= '0;
      rpar_bad <= 1'b0;
    end else begin
      {rx_meta, rx_sync, rx_prev} <= {rx, rx_meta, rx_sync};
      rstate <= r_next;
      rdiv <= (rstate == R_IDLE) ? rx_eff : rdiv;
      rcnt <= (rstate == R_IDLE) ? rx_eff >> 1 : r_tick ? rdiv : rcnt - DIV_W'(1);
      rbit <= (rstate == R_DATA) ? rbit + BW'(r_tick) : '0;
      rsh <= (rstate == R_DATA && r_tick) ? {rx_sync, rsh[DW-1:1]} : rsh;
      rpar_bad <= (rstate == R_IDLE) ? 1'b0 : rpar_bad | set_pe;
    end
  end
  assign empty = wptr == rptr;
  assign full = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign ovf_set = push & full & ~do_pop;
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= rsh;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      fifo_level <= '0;
      tword <= '0;
    end else begin
      wptr <= wptr + (AW+1)'(do_push);
      rptr <= rptr + (AW+1)'(do_pop);
      fifo_level <= fifo_level + (AW+1)'(do_push) - (AW+1)'(do_pop);
      tword <= do_pop ? mem[rptr[AW-1:0]] : tword;
    end
  end
  assign can_pop = ~empty & cts_ok;
  // Leaving STOP one cycle early into LOAD keeps back-to-back frames free of any gap.
  always_comb begin
    t_next = tstate;
    pop = 1'b0;
    case (tstate)
      T_IDLE: begin
        pop = can_pop;
        t_next = can_pop ? T_LOAD : T_IDLE;
      end
      T_LOAD: t_next = T_START;
      T_START: t_next = t_tick ? T_DATA : T_START;
      T_DATA: t_next = (t_tick && tbit == BW'(DW-1)) ? (par_en ? T_PAR : T_STOP) : T_DATA;
      T_PAR: t_next = t_tick ? T_STOP : T_PAR;
      T_STOP: begin
        pop = can_pop && tcnt <= DIV_W'(2);
        t_next = pop ? T_LOAD : t_tick ? T_IDLE : T_STOP;
      end
      default: t_next = T_IDLE;
    endcase
  end
  assign tx_bit = (tstate == T_START) ? 1'b0 : (tstate == T_DATA) ? tword[tbit] :
                  (tstate == T_PAR) ? (^tword ^ par_odd) : 1'b1;
  always_ff @(posedge clk) begin
    if (rst) begin
      tstate <= T_IDLE;
      tcnt <= '0;
      tdiv <= DIV_W'(4);
      tbit <= '0;
      tx <= 1'b1;
      overflow <= 1'b0;
      frame_err <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      tstate <= t_next;
      tdiv <= (tstate == T_LOAD) ? tx_eff : tdiv;
      tcnt <= (tstate == T_LOAD) ? tx_eff : t_tick ? tdiv : tcnt - DIV_W'(1);
      tbit <= (tstate == T_DATA) ? tbit + BW'(t_tick) : '0;
      tx <= tx_bit;
      overflow <= ovf_set | (overflow & ~clr_err);
      frame_err <= set_fe | (frame_err & ~clr_err);
      parity_err <= set_pe | (parity_err & ~clr_err);
    end
  end
endmodule

// File: tb/tb_uart_bridge_param.sv
// tb_uart_bridge_param: randomized bench for uart_bridge_param against a frame-level reference model.
module tb_uart_bridge_param;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam int DIV_W = 16;
  localparam time T = 10;
  logic clk = 0, rst = 1, rx = 1, clr_err = 0;
  logic tx;
  logic [DIV_W-1:0] rx_div = 16, tx_div = 16;
  logic [1:0] par_mode = 0;
  logic [AW:0] fifo_level;
  logic overflow, frame_err, parity_err;
`ifdef UART_CTS_EN
  logic cts_n = 0;
`endif
  int n_vec = 0, n_bad = 0;
  logic [DW-1:0] exp_q[$], got_q[$];
  time start_q[$];
  bit mon_en = 1, exp_fe = 0, exp_pe = 0;
  always #(T/2) clk = ~clk;
  uart_bridge_param #(.DW(DW), .DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .rx(rx), .tx(tx), .rx_div(rx_div), .tx_div(tx_div),
    .par_mode(par_mode), .clr_err(clr_err),
`ifdef UART_CTS_EN
    .cts_n(cts_n),
`endif
    .fifo_level(fifo_level), .overflow(overflow), .frame_err(frame_err), .parity_err(parity_err));
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic bit par_on(logic [1:0] m);
    return m == 2'b01 || m == 2'b10;
  endfunction
  function automatic bit par_bit(logic [DW-1:0] d, logic [1:0] m);
    return (^d) ^ (m == 2'b10);
  endfunction
  function automatic int eff(logic [DIV_W-1:0] d);
    return d < 4 ? 4 : int'(d);
  endfunction
  task automatic drive_bit(bit b, int div);
    @(negedge clk);
    rx = b;
    repeat (div - 1) @(negedge clk);
  endtask
  task automatic send(logic [DW-1:0] d, bit bad_par, bit bad_stop);
    int div = eff(rx_div);
    drive_bit(0, div);
    for (int i = 0; i < DW; i++) drive_bit(d[i], div);
    if (par_on(par_mode)) drive_bit(par_bit(d, par_mode) ^ bad_par, div);
    drive_bit(!bad_stop, div);
    if (bad_stop) drive_bit(1, div);
    if (bad_stop) exp_fe = 1;
    if (par_on(par_mode) && bad_par) exp_pe = 1;
    if (!bad_stop && !(par_on(par_mode) && bad_par)) exp_q.push_back(d);
  endtask
  task automatic wait_drain(int n, int limit);
    int c = 0;
    while ((got_q.size() < n || fifo_level != 0 || tx !== 1'b1) && c < limit) begin
      @(negedge clk);
      c++;
    end
    check("drain_in_time", c < limit, 1);
  endtask
  task automatic compare(string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) check(tag, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
    start_q.delete();
  endtask
  task automatic check_flags(string tag, bit ovf);
    check({tag, "_ovf"}, overflow, ovf);
    check({tag, "_fe"}, frame_err, exp_fe);
    check({tag, "_pe"}, parity_err, exp_pe);
  endtask
  task automatic clear_flags();
    @(negedge clk);
    clr_err = 1;
    @(negedge clk);
    clr_err = 0;
    exp_fe = 0;
    exp_pe = 0;
    check_flags("cleared", 0);
  endtask
  initial forever begin
    logic [DW-1:0] d;
    time t0;
    int dv;
    logic [1:0] pm;
    @(negedge tx);
    t0 = $time;
    dv = eff(tx_div);
    pm = par_mode;
    repeat (dv / 2) @(negedge clk);
    if (mon_en) check("mon_start", tx, 0);
    for (int i = 0; i < DW; i++) begin
      repeat (dv) @(negedge clk);
      d[i] = tx;
    end
    if (par_on(pm)) begin
      repeat (dv) @(negedge clk);
      if (mon_en) check("mon_par", tx, par_bit(d, pm));
    end
    repeat (dv) @(negedge clk);
    if (mon_en) check("mon_stop", tx, 1);
    if (mon_en) begin
      got_q.push_back(d);
      start_q.push_back(t0);
    end
  end
  initial begin
    logic [DW-1:0] sent[$];
    int max_lvl;
    bit done;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_level", fifo_level, 0);
    check_flags("rst", 0);
    rst = 0;
    repeat (4) @(negedge clk);
    fork
      send(8'hA5, 0, 0);
      begin
        int c = 0;
        time tp;
        while (fifo_level == 0 && c < 1000) begin @(negedge clk); c++; end
        tp = $time - T/2;
        c = 0;
        while (tx !== 1'b0 && c < 100) begin @(negedge clk); c++; end
        check("latency", ($time - T/2 - tp) / T, 3);
      end
    join
    wait_drain(1, 1000);
    compare("basic");
    check_flags("basic", 0);
    for (int b = 0; b < 4; b++) begin
      par_mode = 2'($urandom_range(3, 0));
      rx_div = DIV_W'($urandom_range(40, 8));
      tx_div = (b == 0) ? DIV_W'(1) : DIV_W'($urandom_range(24, 4));
      for (int k = 0; k < 6; k++)
        send(DW'($urandom), $urandom_range(5, 0) == 0, $urandom_range(5, 0) == 0);
      wait_drain(exp_q.size(), 5000);
      compare("rand");
      check_flags("rand", 0);
      clear_flags();
    end
    par_mode = 2'b01;
    rx_div = 16;
    tx_div = 16;
    send(8'h07, 0, 0);
    send(8'h07, 1, 0);
    wait_drain(exp_q.size(), 2000);
    compare("parity");
    check_flags("parity", 0);
    check("parity_err_set", parity_err, 1);
    clear_flags();
    par_mode = 2'b00;
    send(8'h3C, 0, 1);
    @(negedge clk);
    rx = 0;
    repeat (3) @(negedge clk);
    rx = 1;
    repeat (100) @(negedge clk);
    check("glitch_level", fifo_level, 0);
    check("glitch_frames", got_q.size(), 0);
    check("frame_err_set", frame_err, 1);
    clear_flags();
    rx_div = 64;
    for (int k = 0; k < 10; k++) send(DW'(k), 0, 0);
    wait_drain(10, 3000);
    compare("rate");
    rx_div = 8;
    tx_div = 200;
    max_lvl = 0;
    done = 0;
    fork
      begin
        for (int k = 0; k < 20; k++) send(DW'($urandom), 0, 0);
        done = 1;
      end
      while (!done) begin
        @(negedge clk);
        if (fifo_level > max_lvl) max_lvl = fifo_level;
      end
    join
    check("ovf_max_level", max_lvl, DEPTH);
    check("ovf_set", overflow, 1);
    while (exp_q.size() > DEPTH + 1) void'(exp_q.pop_back());
    wait_drain(DEPTH + 1, 40000);
    for (int i = 1; i < start_q.size(); i++)
      check("ovf_contiguous", (start_q[i] - start_q[i-1]) / T, 10 * 200);
    compare("ovf");
    check("ovf_sticky", overflow, 1);
    clear_flags();
`ifdef UART_CTS_EN
    rx_div = 16;
    tx_div = 16;
    cts_n = 1;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 3; k++) send(DW'($urandom), 0, 0);
    repeat (100) @(negedge clk);
    check("cts_hold_tx", tx, 1);
    check("cts_hold_level", fifo_level, 3);
    cts_n = 0;
    wait_drain(3, 2000);
    compare("cts");
`endif
    rx_div = 8;
    tx_div = 50;
    for (int k = 0; k < 3; k++) send(DW'($urandom), 0, 0);
    repeat (20) @(negedge clk);
    check("pre_rst_level", fifo_level, 2);
    check("pre_rst_busy", got_q.size(), 0);
    mon_en = 0;
    rst = 1;
    @(negedge clk);
    check("mid_rst_tx", tx, 1);
    check("mid_rst_level", fifo_level, 0);
    rst = 0;
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
